reg_transfer_sequencer: RTL and testbench

Multi-cycle controller that sequences a bank of four 8-bit load/clear registers and their shared operand muxes and adder. It accepts one transfer command at a time over a Start/Ready handshake. For each command it drives the per-register Load/Clear strobes, the operand mux selects and the write-source select, then pulses Done. It sits between the instruction/decode logic and the register bank.

---
 rtl/reg_transfer_sequencer_pkg.sv | 44 ++++
 rtl/reg_transfer_sequencer_sel_decoder.sv | 20 ++
 rtl/reg_transfer_sequencer.sv | 126 ++++++++++++
 tb/tb_reg_transfer_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_transfer_sequencer_pkg.sv
// Shared definitions for the register-transfer sequencer: opcode, state and
// write-source encodings, bank geometry and the latched command record.
package reg_seq_pkg;

    localparam int NREG  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_MOV = 2'b01,
        OP_CLR = 2'b10,
        OP_ADD = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        WR_IMM = 2'b00,
        WR_BUS = 2'b01,
        WR_SUM = 2'b10
    } wr_src_t;

    // Register-index fields of a command, captured together on acceptance.
    typedef struct packed {
        opcode_t          opcode;
        logic [SEL_W-1:0] dst;
        logic [SEL_W-1:0] src;
    } cmd_t;

    // Write-data source implied by an opcode; CLR does not load, so its value is unused.
    function automatic wr_src_t wr_src_of(input opcode_t op);
        case (op)
            OP_MOV:  return WR_BUS;
            OP_ADD:  return WR_SUM;
            default: return WR_IMM;
        endcase
    endfunction

endpackage

// File: rtl/reg_transfer_sequencer_sel_decoder.sv
// Index-plus-enable to one-hot decoder, used for both the load and the clear
// strobe vectors of the register bank.
module sel_decoder
    import reg_seq_pkg::*;
(
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_en,
    output logic [NREG-1:0]  o_onehot
);

    // Decode the selected index into a single high bit when enabled.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Multi-cycle controller for a bank of four load/clear registers with shared
// operand muxes and adder. Accepts one command at a time over Start/Ready,
// drives the bank strobes and mux selects, then pulses Done.
// Optional build macro SEQ_PROTECT_R0_EN: register 0 becomes read-only; a
// non-CLR write to it runs the normal sequence without a strobe and flags Err.
module reg_transfer_sequencer
    import reg_seq_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_start,
    output logic             o_ready,
    input  logic [1:0]       i_opcode,
    input  logic [SEL_W-1:0] i_dst_sel,
    input  logic [SEL_W-1:0] i_src_sel,
    input  logic [WIDTH-1:0] i_imm,
    output logic [NREG-1:0]  o_reg_load,
    output logic [NREG-1:0]  o_reg_clear,
    output logic [SEL_W-1:0] o_a_sel,
    output logic [SEL_W-1:0] o_b_sel,
    output logic [1:0]       o_wr_src,
    output logic [WIDTH-1:0] o_imm_out,
    output logic             o_done,
    output logic             o_err
);

    state_t           r_state;
    state_t           w_next_state;
    cmd_t             r_cmd;
    logic [WIDTH-1:0] r_imm;

    logic             w_accept;
    logic             w_is_clr;
    logic             w_protect;
    logic             w_load_en;
    logic             w_clear_en;
    logic [NREG-1:0]  w_load_dec;
    logic [NREG-1:0]  w_clear_dec;

    assign w_accept = (r_state == IDLE) && i_start;
    assign w_is_clr = (r_cmd.opcode == OP_CLR);

`ifdef SEQ_PROTECT_R0_EN
    // Register 0 is read-only except for an explicit clear.
    assign w_protect = (r_cmd.dst == '0) && !w_is_clr;
`else
    assign w_protect = 1'b0;
`endif

    // State register; Clear aborts any command in flight.
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (i_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing: IDLE -> [READ] -> WRITE -> DONE -> IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_opcode == OP_MOV || i_opcode == OP_ADD) begin
                        w_next_state = READ;
                    end else begin
                        w_next_state = WRITE;
                    end
                end
            end
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Command latch: captured on acceptance, held until the next acceptance.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_cmd <= '{opcode: OP_LDI, dst: '0, src: '0};
            r_imm <= '0;
        end else if (w_accept) begin
            r_cmd <= '{opcode: opcode_t'(i_opcode), dst: i_dst_sel, src: i_src_sel};
            r_imm <= i_imm;
        end
    end

    // Exactly one of the two strobe decoders may fire, and only in WRITE.
    assign w_load_en  = (r_state == WRITE) && !w_is_clr && !w_protect;
    assign w_clear_en = (r_state == WRITE) && w_is_clr;

    sel_decoder u_load_dec (
        .i_sel    (r_cmd.dst),
        .i_en     (w_load_en),
        .o_onehot (w_load_dec)
    );

    sel_decoder u_clear_dec (
        .i_sel    (r_cmd.dst),
        .i_en     (w_clear_en),
        .o_onehot (w_clear_dec)
    );

    // Clear overrides the strobes directly so the bank resets in the same cycle.
    assign o_reg_load  = i_clear ? '0 : w_load_dec;
    assign o_reg_clear = i_clear ? '1 : w_clear_dec;

    assign o_ready   = (r_state == IDLE);
    assign o_done    = (r_state == DONE);
    assign o_a_sel   = r_cmd.src;
    assign o_b_sel   = r_cmd.dst;
    assign o_wr_src  = wr_src_of(r_cmd.opcode);
    assign o_imm_out = r_imm;

`ifdef SEQ_PROTECT_R0_EN
    assign o_err = o_done && w_protect;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Self-checking bench for reg_transfer_sequencer: directed scenarios plus
// randomized commands against a command-level register-file model. A small
// bank model driven by the DUT strobes supplies the register values seen in DONE.
module tb_reg_transfer_sequencer;

    localparam logic [1:0] LDI = 2'd0;
    localparam logic [1:0] MOV = 2'd1;
    localparam logic [1:0] CLR = 2'd2;
    localparam logic [1:0] ADD = 2'd3;

`ifdef SEQ_PROTECT_R0_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_clear, i_start;
    logic [1:0] i_opcode, i_dst_sel, i_src_sel;
    logic [7:0] i_imm;
    logic       o_ready, o_done, o_err;
    logic [3:0] o_reg_load, o_reg_clear;
    logic [1:0] o_a_sel, o_b_sel, o_wr_src;
    logic [7:0] o_imm_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] bank  [4];
    logic [7:0] model [4];

    always #5 clk = ~clk;

    reg_transfer_sequencer #(.WIDTH(8)) dut (
        .i_clock     (clk),
        .i_clear     (i_clear),
        .i_start     (i_start),
        .o_ready     (o_ready),
        .i_opcode    (i_opcode),
        .i_dst_sel   (i_dst_sel),
        .i_src_sel   (i_src_sel),
        .i_imm       (i_imm),
        .o_reg_load  (o_reg_load),
        .o_reg_clear (o_reg_clear),
        .o_a_sel     (o_a_sel),
        .o_b_sel     (o_b_sel),
        .o_wr_src    (o_wr_src),
        .o_imm_out   (o_imm_out),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    // Register bank with operand muxes and adder, driven by the DUT controls.
    always @(posedge clk) begin
        logic [7:0] wd;
        case (o_wr_src)
            2'd0:    wd = o_imm_out;
            2'd1:    wd = bank[o_a_sel];
            default: wd = bank[o_a_sel] + bank[o_b_sel];
        endcase
        for (int i = 0; i < 4; i++) begin
            if (o_reg_clear[i])     bank[i] <= 8'd0;
            else if (o_reg_load[i]) bank[i] <= wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // While busy, either hold Start high with fresh junk fields or drop it.
    task automatic drive_busy(input bit hold);
        i_start   = hold;
        i_opcode  = 2'($urandom);
        i_dst_sel = 2'($urandom);
        i_src_sel = 2'($urandom);
        i_imm     = 8'($urandom);
    endtask

    // Issue one command and check every cycle until Ready returns.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                          input logic [7:0] imm, input bit hold);
        int         waitc = 0;
        bit         two, err;
        logic [3:0] ld, cl;
        logic [1:0] ws;
        logic [7:0] newval;
        while (!o_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_cmd", 32'(o_ready), 32'd1);
        i_start = 1'b1; i_opcode = op; i_dst_sel = dst; i_src_sel = src; i_imm = imm;

        two = (op == MOV) || (op == ADD);
        err = PROT && (dst == 2'd0) && (op != CLR);
        ws  = (op == MOV) ? 2'd1 : (op == ADD) ? 2'd2 : 2'd0;
        ld  = (op != CLR && !err) ? (4'b0001 << dst) : 4'b0000;
        cl  = (op == CLR) ? (4'b0001 << dst) : 4'b0000;
        case (op)
            LDI:     newval = imm;
            MOV:     newval = model[src];
            CLR:     newval = 8'd0;
            default: newval = 8'((int'(model[dst]) + int'(model[src])) % 256);
        endcase
        if (!err) model[dst] = newval;

        @(posedge clk);
        @(negedge clk);
        drive_busy(hold);
        if (two) begin
            check("read_ready",  32'(o_ready), 32'd0);
            check("read_load",   32'(o_reg_load), 32'd0);
            check("read_clear",  32'(o_reg_clear), 32'd0);
            check("read_done",   32'(o_done), 32'd0);
            check("read_asel",   32'(o_a_sel), 32'(src));
            check("read_bsel",   32'(o_b_sel), 32'(dst));
            check("read_wrsrc",  32'(o_wr_src), 32'(ws));
            @(negedge clk);
            drive_busy(hold);
        end
        check("write_load",  32'(o_reg_load), 32'(ld));
        check("write_clear", 32'(o_reg_clear), 32'(cl));
        check("write_ready", 32'(o_ready), 32'd0);
        check("write_done",  32'(o_done), 32'd0);
        check("write_asel",  32'(o_a_sel), 32'(src));
        check("write_bsel",  32'(o_b_sel), 32'(dst));
        check("write_wrsrc", 32'(o_wr_src), 32'(ws));
        check("write_imm",   32'(o_imm_out), 32'(imm));
        @(negedge clk);
        drive_busy(hold);
        check("done_done",   32'(o_done), 32'd1);
        check("done_err",    32'(o_err), 32'(err));
        check("done_ready",  32'(o_ready), 32'd0);
        check("done_load",   32'(o_reg_load), 32'd0);
        check("done_asel",   32'(o_a_sel), 32'(src));
        check("done_bsel",   32'(o_b_sel), 32'(dst));
        check("done_regval", 32'(bank[dst]), 32'(model[dst]));
        @(negedge clk);
        i_start = 1'b0;
        check("after_ready", 32'(o_ready), 32'd1);
        check("after_done",  32'(o_done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) model[i] = 8'd0;
        i_clear = 1'b0; i_start = 1'b0;
        i_opcode = 2'd0; i_dst_sel = 2'd0; i_src_sel = 2'd0; i_imm = 8'd0;

        // Clear for two cycles with Start high: bank clear forced, nothing accepted.
        @(negedge clk);
        i_clear = 1'b1; i_start = 1'b1; i_opcode = LDI; i_dst_sel = 2'd1; i_imm = 8'hA5;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("clr_regclear", 32'(o_reg_clear), 32'hF);
            check("clr_regload",  32'(o_reg_load), 32'h0);
            @(negedge clk);
        end
        i_clear = 1'b0; i_start = 1'b0;
        #1;
        check("rst_ready",  32'(o_ready), 32'd1);
        check("rst_load",   32'(o_reg_load), 32'd0);
        check("rst_clear",  32'(o_reg_clear), 32'd0);
        check("rst_asel",   32'(o_a_sel), 32'd0);
        check("rst_bsel",   32'(o_b_sel), 32'd0);
        check("rst_wrsrc",  32'(o_wr_src), 32'd0);
        check("rst_imm",    32'(o_imm_out), 32'd0);
        check("rst_done",   32'(o_done), 32'd0);
        check("rst_err",    32'(o_err), 32'd0);
        @(negedge clk);
        check("rst_no_accept", 32'(o_ready), 32'd1);

        // Directed: ADD with wrap, LDI, MOV with Start held, protected/unprotected R0.
        do_cmd(LDI, 2'd1, 2'd0, 8'd200, 1'b0);
        do_cmd(LDI, 2'd3, 2'd2, 8'd100, 1'b0);
        do_cmd(ADD, 2'd3, 2'd1, 8'd0,   1'b0);
        check("add_wrap_r3", 32'(bank[3]), 32'd44);
        do_cmd(LDI, 2'd2, 2'd0, 8'd10,  1'b0);
        do_cmd(MOV, 2'd0, 2'd2, 8'd77,  1'b1);
        do_cmd(ADD, 2'd2, 2'd2, 8'd0,   1'b0);
        do_cmd(LDI, 2'd0, 2'd1, 8'd55,  1'b0);
        do_cmd(CLR, 2'd0, 2'd3, 8'd9,   1'b0);
        do_cmd(CLR, 2'd3, 2'd0, 8'd0,   1'b1);

        // CLR aborted by Clear in its WRITE cycle.
        @(negedge clk);
        i_start = 1'b1; i_opcode = CLR; i_dst_sel = 2'd1; i_src_sel = 2'd0; i_imm = 8'd0;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        check("abort_write_clear", 32'(o_reg_clear), 32'h2);
        i_clear = 1'b1;
        #1;
        check("abort_regclear", 32'(o_reg_clear), 32'hF);
        check("abort_regload",  32'(o_reg_load), 32'h0);
        @(negedge clk);
        i_clear = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 8'd0;
        #1;
        check("abort_no_done", 32'(o_done), 32'd0);
        check("abort_ready",   32'(o_ready), 32'd1);
        check("abort_bank1",   32'(bank[1]), 32'd0);
        @(negedge clk);

        // Randomized commands.
        for (int k = 0; k < 60; k++) begin
            do_cmd(2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), bit'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) check("final_bank", 32'(bank[i]), 32'(model[i]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
